// File: rtl/bsg_gateway_reset_seq.sv
// bsg_gateway_reset_seq
//
// Turns the PLL "locked" indication into an ordered set of active-high
// resets for the gateway clock consumers (0 = microblaze, 1 = io master,
// 2 = core). Lock has to stay stable for lock_stable_cycles_p cycles before
// the first consumer is released. After that, one further consumer is
// released every stage_gap_cycles_p cycles. A loss of lock or a software
// request during release or after completion re-asserts every reset and
// starts the sequence again.
//
// The block runs entirely in the microblaze clock domain. locked_i is
// asynchronous to clk_i and is only ever observed through the synchronizer.

module bsg_gateway_reset_seq #(
    parameter int sync_stages_p        = 2,
    parameter int lock_stable_cycles_p = 1024,
    parameter int stage_gap_cycles_p   = 64,
    parameter int num_resets_p         = 3
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    locked_i,
    input  logic                    sw_reset_req_i,
    output logic [num_resets_p-1:0] reset_o,
    output logic                    done_o,
    output logic                    lock_s_o,
    output logic [7:0]              lock_loss_count_o
);

    // ------------------------------------------------------------------
    // Parameter sanity: reported during elaboration
    // ------------------------------------------------------------------
    if (sync_stages_p < 2) begin : g_bad_sync_stages
        $error("bsg_gateway_reset_seq: sync_stages_p must be >= 2");
    end
    if (lock_stable_cycles_p < 1) begin : g_bad_lock_stable
        $error("bsg_gateway_reset_seq: lock_stable_cycles_p must be >= 1");
    end
    if (stage_gap_cycles_p < 1) begin : g_bad_stage_gap
        $error("bsg_gateway_reset_seq: stage_gap_cycles_p must be >= 1");
    end
    if (num_resets_p < 1) begin : g_bad_num_resets
        $error("bsg_gateway_reset_seq: num_resets_p must be >= 1");
    end

    // ------------------------------------------------------------------
    // Widths and terminal counts
    // ------------------------------------------------------------------
    localparam int stab_w_lp = $clog2(lock_stable_cycles_p + 1);
    localparam int gap_w_lp  = $clog2(stage_gap_cycles_p + 1);
    localparam int idx_w_lp  = $clog2(num_resets_p + 1);

    localparam logic [stab_w_lp-1:0] stab_last_lp = stab_w_lp'(lock_stable_cycles_p - 1);
    localparam logic [gap_w_lp-1:0]  gap_last_lp  = gap_w_lp'(stage_gap_cycles_p - 1);
    localparam logic [idx_w_lp-1:0]  idx_last_lp  = idx_w_lp'(num_resets_p - 1);

    // Sequencer states
    localparam logic [1:0] wait_lock_s = 2'd0;
    localparam logic [1:0] stable_s    = 2'd1;
    localparam logic [1:0] release_s   = 2'd2;
    localparam logic [1:0] done_s      = 2'd3;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [sync_stages_p-1:0] sync_q, sync_d;
    logic                     lock_s;

    logic [1:0]               state_q, state_d;
    logic [stab_w_lp-1:0]     stab_cnt_q, stab_cnt_d;
    logic [gap_w_lp-1:0]      gap_cnt_q, gap_cnt_d;
    logic [idx_w_lp-1:0]      idx_q, idx_d;
    logic [num_resets_p-1:0]  reset_q, reset_d;
    logic                     done_q, done_d;
    logic [7:0]               loss_cnt_q, loss_cnt_d;

    logic                     abort;

    // ------------------------------------------------------------------
    // Synchronizer: shift locked_i in at the bottom, and use the top stage
    // ------------------------------------------------------------------
    always_comb begin
        sync_d = (sync_q << 1) | sync_stages_p'(locked_i);
    end

    assign lock_s = sync_q[sync_stages_p-1];

    // A lock loss or a software request ends any release in progress. It is
    // only honoured once stability has been declared.
    assign abort = (!lock_s) || sw_reset_req_i;

    // ------------------------------------------------------------------
    // Next-state logic for the sequencer, the counters and the outputs
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here first gets its hold value, so no path
        // leaves a signal unassigned. An unassigned path would infer a latch.
        state_d    = state_q;
        stab_cnt_d = stab_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        idx_d      = idx_q;
        reset_d    = reset_q;
        done_d     = done_q;
        loss_cnt_d = loss_cnt_q;

        case (state_q)
            wait_lock_s: begin
                reset_d    = '1;
                done_d     = 1'b0;
                stab_cnt_d = '0;
                gap_cnt_d  = '0;
                idx_d      = '0;
                if (lock_s) begin
                    state_d = stable_s;
                end
            end

            stable_s: begin
                if (!lock_s) begin
                    // A glitch before stability only restarts the wait.
                    // It is not counted as a lock loss.
                    state_d    = wait_lock_s;
                    stab_cnt_d = '0;
                end else if (stab_cnt_q == stab_last_lp) begin
                    reset_d[0] = 1'b0;
                    gap_cnt_d  = '0;
                    idx_d      = idx_w_lp'(1);
                    if (num_resets_p == 1) begin
                        state_d = done_s;
                        done_d  = 1'b1;
                    end else begin
                        state_d = release_s;
                    end
                end else begin
                    stab_cnt_d = stab_cnt_q + stab_w_lp'(1);
                end
            end

            release_s, done_s: begin
                if (abort) begin
                    state_d    = wait_lock_s;
                    reset_d    = '1;
                    done_d     = 1'b0;
                    stab_cnt_d = '0;
                    gap_cnt_d  = '0;
                    idx_d      = '0;
                    // A lock loss together with a software request counts once.
                    if (!lock_s && (loss_cnt_q != 8'hFF)) begin
                        loss_cnt_d = loss_cnt_q + 8'd1;
                    end
                end else if (state_q == release_s) begin
                    if (gap_cnt_q == gap_last_lp) begin
                        for (int i = 0; i < num_resets_p; i++) begin
                            if (idx_w_lp'(i) == idx_q) begin
                                reset_d[i] = 1'b0;
                            end
                        end
                        gap_cnt_d = '0;
                        idx_d     = idx_q + idx_w_lp'(1);
                        if (idx_q == idx_last_lp) begin
                            state_d = done_s;
                            done_d  = 1'b1;
                        end
                    end else begin
                        gap_cnt_d = gap_cnt_q + gap_w_lp'(1);
                    end
                end else begin
                    // In the done state every consumer stays released.
                    reset_d = '0;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = wait_lock_s;
                reset_d = '1;
                done_d  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers. A synchronous reset overrides every other update.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments, so every flop samples the values
        // from before the edge, whatever order the statements are in.
        if (reset_i) begin
            sync_q     <= '0;
            state_q    <= wait_lock_s;
            stab_cnt_q <= '0;
            gap_cnt_q  <= '0;
            idx_q      <= '0;
            reset_q    <= '1;
            done_q     <= 1'b0;
            loss_cnt_q <= '0;
        end else begin
            sync_q     <= sync_d;
            state_q    <= state_d;
            stab_cnt_q <= stab_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            idx_q      <= idx_d;
            reset_q    <= reset_d;
            done_q     <= done_d;
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign reset_o           = reset_q;
    assign done_o            = done_q;
    assign lock_s_o          = lock_s;
    assign lock_loss_count_o = loss_cnt_q;

    // ------------------------------------------------------------------
    // Invariants
    // ------------------------------------------------------------------
    // A consumer is never released while a lower-indexed consumer is still held.
    a_release_order: assert property (@(posedge clk_i) disable iff (reset_i)
        ((reset_q << 1) & ~reset_q) == '0);

    // done is set exactly in the done state, and then every reset is released.
    a_done_state: assert property (@(posedge clk_i) disable iff (reset_i)
        (done_q == (state_q == done_s)) && (!done_q || (reset_q == '0)));

endmodule
